// File: rtl/sram_req_arbiter_if.sv
// sram-like request/response bundle. The master modport drives the
// request fields; the slave modport answers with addr_ok/data_ok/rdata.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like bus.
// Tracks up to OUTSTANDING accepted requests in a 1-bit tag FIFO and
// steers each in-order response back to the master that issued it.
module sram_req_arbiter #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned TAG_AW      = 2
) (
  input  logic                clk,
  input  logic                resetn,
  sram_req_arbiter_if.slave   inst,
  sram_req_arbiter_if.slave   data,
  sram_req_arbiter_if.master  s,
  output logic                err_unexpected
);

  localparam int unsigned CW    = TAG_AW + 1;
  localparam int unsigned DEPTH = 1 << TAG_AW;
  localparam logic [CW-1:0]     COUNT_FULL = CW'(OUTSTANDING);
  localparam logic [TAG_AW-1:0] PTR_LAST   = TAG_AW'(OUTSTANDING - 1);

  // A grant offered but not yet accepted is remembered so it cannot be
  // stolen by the other master raising req in the meantime.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD_INST,
    ST_HOLD_DATA
  } hold_e;

  hold_e             state_q, state_d;
  logic [DEPTH-1:0]  tag_q, tag_d;
  logic [TAG_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              last_grant_q, last_grant_d;
  logic              err_q, err_d;

  logic gnt_valid, gnt_sel, both, full, accept, has_out, resp, head;

  function automatic logic [TAG_AW-1:0] ptr_inc(input logic [TAG_AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Grant selection: hold pending offer, else alternate on conflict.
  // Reset gates the grant so nothing is offered while resetn is low.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = 1'b0;
    both      = inst.req & data.req;
    full      = (count_q == COUNT_FULL);
    if (resetn && !full) begin
      if (state_q == ST_HOLD_INST && inst.req) begin
        gnt_valid = 1'b1;
        gnt_sel   = 1'b0;
      end else if (state_q == ST_HOLD_DATA && data.req) begin
        gnt_valid = 1'b1;
        gnt_sel   = 1'b1;
      end else if (both) begin
        gnt_valid = 1'b1;
        gnt_sel   = ~last_grant_q;
      end else if (data.req) begin
        gnt_valid = 1'b1;
        gnt_sel   = 1'b1;
      end else if (inst.req) begin
        gnt_valid = 1'b1;
        gnt_sel   = 1'b0;
      end
    end
  end

  assign s.req   = gnt_valid;
  assign s.wr    = gnt_sel ? data.wr    : inst.wr;
  assign s.size  = gnt_sel ? data.size  : inst.size;
  assign s.addr  = gnt_sel ? data.addr  : inst.addr;
  assign s.wstrb = gnt_sel ? data.wstrb : inst.wstrb;
  assign s.wdata = gnt_sel ? data.wdata : inst.wdata;

  assign accept  = gnt_valid & s.addr_ok;
  assign has_out = (count_q != '0);
  assign resp    = resetn & s.data_ok & has_out;
  assign head    = tag_q[rd_ptr_q];

  assign inst.addr_ok = accept & ~gnt_sel;
  assign data.addr_ok = accept &  gnt_sel;
  assign inst.data_ok = resp & ~head;
  assign data.data_ok = resp &  head;
  assign inst.rdata   = inst.data_ok ? s.rdata : '0;
  assign data.rdata   = data.data_ok ? s.rdata : '0;

  assign err_unexpected = err_q;

  // Next-state: tag FIFO push/pop, conflict history, hold state, error flag.
  always_comb begin
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | (s.data_ok & ~has_out);
    state_d      = ST_IDLE;
    if (accept) begin
      tag_d[wr_ptr_q] = gnt_sel;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      if (both) last_grant_d = gnt_sel;
    end
    if (resp) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({accept, resp})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (gnt_valid && !s.addr_ok) state_d = gnt_sel ? ST_HOLD_DATA : ST_HOLD_INST;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: inputs change 1 ns after the rising
// edge, combinational outputs are checked 3 ns later, before the next edge.
module tb_sram_req_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic err_unexpected;
  int unsigned checks = 0;
  int unsigned errors = 0;

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if s_if ();

  sram_req_arbiter #(.OUTSTANDING(2), .TAG_AW(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst           (inst_if),
    .data           (data_if),
    .s              (s_if),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.addr = '0;
    inst_if.wstrb = '0; inst_if.wdata = '0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.addr = '0;
    data_if.wstrb = '0; data_if.wdata = '0;
    s_if.addr_ok = 0; s_if.data_ok = 0; s_if.rdata = '0;
  endtask

  initial begin
    // Reset, with a master already requesting
    resetn = 1'b0;
    clear_inputs();
    inst_if.req = 1; inst_if.addr = 32'hBFC00000; s_if.addr_ok = 1; s_if.data_ok = 1;
    #2;
    check("rst_sreq",  s_if.req, 0);
    check("rst_iaok",  inst_if.addr_ok, 0);
    check("rst_daok",  data_if.addr_ok, 0);
    check("rst_idok",  inst_if.data_ok, 0);
    check("rst_ddok",  data_if.data_ok, 0);
    check("rst_err",   err_unexpected, 0);
    clear_inputs();
    step(); step();
    resetn = 1'b1;

    // Inst-only reads, answered two cycles after issue
    inst_if.req = 1; inst_if.addr = 32'hBFC00000; s_if.addr_ok = 1;
    #3;
    check("t1_sreq",  s_if.req, 1);
    check("t1_saddr0", s_if.addr, 32'hBFC00000);
    check("t1_iaok0", inst_if.addr_ok, 1);
    check("t1_daok0", data_if.addr_ok, 0);
    step();
    inst_if.addr = 32'hBFC00004;
    #3;
    check("t1_saddr1", s_if.addr, 32'hBFC00004);
    check("t1_iaok1", inst_if.addr_ok, 1);
    step();
    inst_if.req = 0; s_if.addr_ok = 0; s_if.data_ok = 1; s_if.rdata = 32'hA0A0A0A0;
    #3;
    check("t1_idok0",  inst_if.data_ok, 1);
    check("t1_irdat0", inst_if.rdata, 32'hA0A0A0A0);
    check("t1_ddok0",  data_if.data_ok, 0);
    check("t1_drdat0", data_if.rdata, 0);
    step();
    s_if.rdata = 32'hA1A1A1A1;
    #3;
    check("t1_idok1",  inst_if.data_ok, 1);
    check("t1_irdat1", inst_if.rdata, 32'hA1A1A1A1);
    step();
    s_if.data_ok = 0;

    // Both masters request every cycle: data, inst, (full), data, inst
    inst_if.req = 1; inst_if.addr = 32'hBFC00010;
    data_if.req = 1; data_if.addr = 32'h1FAF0010; s_if.addr_ok = 1;
    #3;
    check("t2_c1_daok",  data_if.addr_ok, 1);
    check("t2_c1_iaok",  inst_if.addr_ok, 0);
    check("t2_c1_saddr", s_if.addr, 32'h1FAF0010);
    step();
    #3;
    check("t2_c2_iaok",  inst_if.addr_ok, 1);
    check("t2_c2_daok",  data_if.addr_ok, 0);
    check("t2_c2_saddr", s_if.addr, 32'hBFC00010);
    step();
    s_if.data_ok = 1; s_if.rdata = 32'hB0B0B0B0;
    #3;
    check("t2_full_sreq", s_if.req, 0);
    check("t2_full_iaok", inst_if.addr_ok, 0);
    check("t2_full_daok", data_if.addr_ok, 0);
    check("t2_c3_ddok",   data_if.data_ok, 1);
    check("t2_c3_idok",   inst_if.data_ok, 0);
    check("t2_c3_drdat",  data_if.rdata, 32'hB0B0B0B0);
    step();
    s_if.rdata = 32'hB1B1B1B1;
    #3;
    check("t2_c4_daok",  data_if.addr_ok, 1);
    check("t2_c4_idok",  inst_if.data_ok, 1);
    check("t2_c4_irdat", inst_if.rdata, 32'hB1B1B1B1);
    step();
    s_if.rdata = 32'hB2B2B2B2;
    #3;
    check("t2_c5_iaok", inst_if.addr_ok, 1);
    check("t2_c5_ddok", data_if.data_ok, 1);
    check("t2_c5_idok", inst_if.data_ok, 0);
    step();
    inst_if.req = 0; data_if.req = 0; s_if.addr_ok = 0; s_if.rdata = 32'hB3B3B3B3;
    #3;
    check("t2_c6_idok", inst_if.data_ok, 1);
    check("t2_c6_sreq", s_if.req, 0);
    step();
    s_if.data_ok = 0;

    // Offered grant holds until accepted even when the other master joins
    inst_if.req = 1; inst_if.addr = 32'hBFC00020;
    #3;
    check("hold_sreq",  s_if.req, 1);
    check("hold_saddr", s_if.addr, 32'hBFC00020);
    check("hold_iaok0", inst_if.addr_ok, 0);
    step();
    data_if.req = 1; data_if.addr = 32'h1FAF0020;
    #3;
    check("hold_saddr_keep", s_if.addr, 32'hBFC00020);
    check("hold_daok", data_if.addr_ok, 0);
    step();
    s_if.addr_ok = 1;
    #3;
    check("hold_iaok1", inst_if.addr_ok, 1);
    check("hold_daok1", data_if.addr_ok, 0);
    step();
    inst_if.req = 0;
    #3;
    check("hold_daok2",  data_if.addr_ok, 1);
    check("hold_saddr2", s_if.addr, 32'h1FAF0020);
    step();
    data_if.req = 0; s_if.addr_ok = 0; s_if.data_ok = 1; s_if.rdata = 32'hC0C0C0C0;
    #3;
    check("hold_idok", inst_if.data_ok, 1);
    step();
    s_if.rdata = 32'hC1C1C1C1;
    #3;
    check("hold_ddok",  data_if.data_ok, 1);
    check("hold_drdat", data_if.rdata, 32'hC1C1C1C1);
    check("hold_irdat", inst_if.rdata, 0);
    step();
    s_if.data_ok = 0;

    // Data write then inst read; field mux and response order
    data_if.req = 1; data_if.wr = 1; data_if.size = 2'd2; data_if.addr = 32'h1FAF0000;
    data_if.wstrb = 4'b0011; data_if.wdata = 32'h12345678; s_if.addr_ok = 1;
    #3;
    check("t3_swr1",   s_if.wr, 1);
    check("t3_saddr",  s_if.addr, 32'h1FAF0000);
    check("t3_swstrb", s_if.wstrb, 4'b0011);
    check("t3_swdata", s_if.wdata, 32'h12345678);
    check("t3_ssize",  s_if.size, 2'd2);
    check("t3_daok",   data_if.addr_ok, 1);
    step();
    data_if.req = 0; data_if.wr = 0;
    inst_if.req = 1; inst_if.wr = 0; inst_if.addr = 32'hBFC00008;
    #3;
    check("t3_swr0",   s_if.wr, 0);
    check("t3_saddr2", s_if.addr, 32'hBFC00008);
    check("t3_iaok",   inst_if.addr_ok, 1);
    step();
    inst_if.req = 0; s_if.addr_ok = 0; s_if.data_ok = 1; s_if.rdata = 32'h0;
    #3;
    check("t3_ddok", data_if.data_ok, 1);
    check("t3_idok0", inst_if.data_ok, 0);
    step();
    s_if.rdata = 32'hDEADBEEF;
    #3;
    check("t3_idok",  inst_if.data_ok, 1);
    check("t3_irdat", inst_if.rdata, 32'hDEADBEEF);
    check("t3_drdat", data_if.rdata, 0);
    step();
    s_if.data_ok = 0;

    // Response with nothing outstanding
    step();
    s_if.data_ok = 1; s_if.rdata = 32'h55555555;
    #3;
    check("t4_idok", inst_if.data_ok, 0);
    check("t4_ddok", data_if.data_ok, 0);
    check("t4_err_pre", err_unexpected, 0);
    step();
    s_if.data_ok = 0;
    #3;
    check("t4_err_set", err_unexpected, 1);
    step(); step();
    #3;
    check("t4_err_sticky", err_unexpected, 1);

    // Asynchronous reset mid-cycle with two requests outstanding
    step();
    inst_if.req = 1; inst_if.addr = 32'hBFC00030; s_if.addr_ok = 1;
    step();
    step();
    #2;
    resetn = 1'b0; s_if.data_ok = 1;
    #1;
    check("t5_sreq",  s_if.req, 0);
    check("t5_iaok",  inst_if.addr_ok, 0);
    check("t5_idok",  inst_if.data_ok, 0);
    check("t5_ddok",  data_if.data_ok, 0);
    check("t5_err",   err_unexpected, 0);
    s_if.data_ok = 0;
    step(); step();
    resetn = 1'b1;
    inst_if.addr = 32'hBFC00040;
    #3;
    check("t5_post_iaok",  inst_if.addr_ok, 1);
    check("t5_post_saddr", s_if.addr, 32'hBFC00040);
    step();
    inst_if.req = 0; s_if.addr_ok = 0; s_if.data_ok = 1; s_if.rdata = 32'h77777777;
    #3;
    check("t5_post_idok",  inst_if.data_ok, 1);
    check("t5_post_irdat", inst_if.rdata, 32'h77777777);
    check("t5_post_ddok",  data_if.data_ok, 0);
    step();
    s_if.data_ok = 0;
    #3;
    check("t5_post_err", err_unexpected, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
